// File: rtl/rc4_pkg.sv
// Shared types and default sizing for the RC4 keystream consumer.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int KS_DEPTH_DEF = 4;
  localparam int LEN_W_DEF    = 16;

endpackage

// File: rtl/rc4_stream_xor_if.sv
// Keystream, data-in and data-out byte streams between the XOR stage and its neighbours.
interface rc4_stream_xor_if;
  import rc4_pkg::*;

  // All three streams: a byte moves on a rising edge where valid && ready;
  // while valid is high and ready is low the producer holds its byte unchanged.
  logic  ks_valid;
  byte_t ks_byte;
  logic  ks_ready;
  logic  din_valid;
  byte_t din;
  logic  din_ready;
  logic  dout_valid;
  byte_t dout;
  logic  dout_ready;

  modport master (
    output ks_valid, ks_byte, din_valid, din, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout
  );

  modport slave (
    input  ks_valid, ks_byte, din_valid, din, dout_ready,
    output ks_ready, din_ready, dout_valid, dout
  );

endinterface

// File: rtl/rc4_ks_fifo.sv
// Keystream byte FIFO; binary pointers carry one extra wrap bit to tell full from empty.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = KS_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  byte_t wdata,
  output byte_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  byte_t       mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push is refused while full even if a pop frees a slot on the same edge.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rc4_stream_xor.sv
// XORs each data byte with the next buffered RC4 keystream byte, one message per start pulse.
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = KS_DEPTH_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  rc4_stream_xor_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_count,
  output state_t           state_dbg
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  byte_t            dout_q;
  logic             dout_valid_q;
  byte_t            fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             start_acc;
  logic             ks_push;
  logic             out_free;
  logic             din_xfer;

  assign start_acc = (state == IDLE) && start;
  // Keystream intake is closed on the start-accept edge so every message begins on fresh bytes.
  assign bus.ks_ready  = !rst && !fifo_full && !start_acc;
  assign ks_push       = bus.ks_valid && bus.ks_ready;
  assign out_free      = !dout_valid_q || bus.dout_ready;
  assign bus.din_ready = (state == RUN) && !fifo_empty && out_free && (remaining != '0);
  assign din_xfer      = bus.din_valid && bus.din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign state_dbg      = state;

  rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ks_push),
    .pop   (din_xfer),
    .flush (start_acc),
    .wdata (bus.ks_byte),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      byte_count   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (din_xfer) begin
        dout_q       <= bus.din ^ fifo_head;
        dout_valid_q <= 1'b1;
        remaining    <= remaining - LEN_W'(1);
        byte_count   <= byte_count + LEN_W'(1);
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            byte_count <= '0;
            if (msg_len != '0) begin
              remaining <= msg_len;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (din_xfer && (remaining == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (out_free) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: directed scenarios plus randomized messages against a queue-based model.
module tb_rc4_stream_xor;
  import rc4_pkg::*;

  localparam int KS_DEPTH = 4;
  localparam int LEN_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_count;
  state_t           state_dbg;

  rc4_stream_xor_if bus();

  rc4_stream_xor #(.KS_DEPTH(KS_DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ks_model[$];
  logic [7:0] out_log[$];
  int         m_rem, m_count, m_timer;
  bit         m_active, m_drain, m_idle;
  bit         ks_auto, din_auto, rdy_auto;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] log_get(input int i);
    return (i < out_log.size()) ? out_log[i] : 8'hxx;
  endfunction

  // ---------------- monitor + reference model ----------------
  initial begin
    bit         start_acc, exp_ks_rdy, exp_din_rdy;
    logic [7:0] k;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ks_ready", bus.ks_ready, 0);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_state", state_dbg, IDLE);
        exp_q.delete(); ks_model.delete();
        m_rem = 0; m_count = 0; m_timer = 0;
        m_active = 0; m_drain = 0; m_idle = 1;
      end else begin
        start_acc   = start && m_idle;
        exp_ks_rdy  = !start_acc && (ks_model.size() < KS_DEPTH);
        exp_din_rdy = m_active && (m_rem != 0) && (ks_model.size() != 0) &&
                      (exp_q.size() == 0 || bus.dout_ready);
        chk("done", done, (m_timer == 1));
        chk("busy", busy, m_active);
        chk("byte_count", byte_count, m_count);
        chk("dout_valid", bus.dout_valid, (exp_q.size() != 0));
        if (bus.dout_valid && exp_q.size() != 0) chk("dout", bus.dout, exp_q[0]);
        chk("ks_ready", bus.ks_ready, exp_ks_rdy);
        chk("din_ready", bus.din_ready, exp_din_rdy);

        if (m_timer == 2) m_idle = 1;
        if (m_timer > 0) m_timer--;
        if (bus.dout_valid && bus.dout_ready && exp_q.size() != 0) begin
          out_log.push_back(bus.dout);
          void'(exp_q.pop_front());
        end
        if (m_drain && exp_q.size() == 0) begin
          m_drain = 0; m_active = 0; m_timer = 2;
        end
        if (bus.din_valid && exp_din_rdy) begin
          k = ks_model.pop_front();
          exp_q.push_back(bus.din ^ k);
          m_rem--; m_count++;
          if (m_rem == 0) m_drain = 1;
        end
        if (bus.ks_valid && exp_ks_rdy) ks_model.push_back(bus.ks_byte);
        if (start_acc) begin
          ks_model.delete();
          m_idle = 0; m_count = 0;
          if (msg_len != 0) begin
            m_active = 1; m_rem = int'(msg_len);
          end else begin
            m_timer = 2;
          end
        end
      end
    end
  end

  // ---------------- random background producers ----------------
  bit ks_fire_p, din_fire_p;

  initial begin
    forever begin
      @(negedge clk); ks_fire_p = bus.ks_valid && bus.ks_ready;
      @(posedge clk); #1;
      if (ks_auto && (!bus.ks_valid || ks_fire_p)) begin
        bus.ks_valid = ($urandom_range(0, 3) != 0);
        bus.ks_byte  = 8'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); din_fire_p = bus.din_valid && bus.din_ready;
      @(posedge clk); #1;
      if (din_auto && (!bus.din_valid || din_fire_p)) begin
        bus.din_valid = ($urandom_range(0, 3) != 0);
        bus.din       = 8'($urandom);
      end
      if (rdy_auto) bus.dout_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ks_wait();
    bit hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk); hit = bus.ks_ready;
    end
    chk("ks_timeout", hit, 1);
    step();
    bus.ks_valid = 0;
  endtask

  task automatic din_wait();
    bit hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk); hit = bus.din_ready;
    end
    chk("din_timeout", hit, 1);
    step();
    bus.din_valid = 0;
  endtask

  task automatic send_ks(input logic [7:0] b);
    bus.ks_valid = 1; bus.ks_byte = b;
    ks_wait();
  endtask

  task automatic send_din(input logic [7:0] b);
    bus.din_valid = 1; bus.din = b;
    din_wait();
  endtask

  task automatic start_msg(input int len);
    start = 1; msg_len = LEN_W'(len);
    step();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk); hit = done;
    end
    chk("done_timeout", hit, 1);
    step();
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int         base;
    logic [7:0] k0, k1, x0, x1;
    rst = 0; start = 0; msg_len = '0;
    bus.ks_valid = 0; bus.ks_byte = '0; bus.din_valid = 0; bus.din = '0; bus.dout_ready = 0;
    ks_auto = 0; din_auto = 0; rdy_auto = 0;
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Known-answer message, back-to-back data
    bus.dout_ready = 1;
    base = out_log.size();
    start_msg(3);
    send_ks(8'h12); send_ks(8'h34); send_ks(8'h56);
    send_din(8'h41); send_din(8'h42); send_din(8'h43);
    wait_done(20);
    chk("t1_b0", log_get(base), 8'h53);
    chk("t1_b1", log_get(base + 1), 8'h76);
    chk("t1_b2", log_get(base + 2), 8'h15);
    chk("t1_count", byte_count, 3);

    // Zero-length message
    bus.din_valid = 1; bus.din = 8'h99;
    start_msg(0);
    wait_done(5);
    chk("t2_count", byte_count, 0);
    bus.din_valid = 0;

    // Keystream overfill while idle; start flushes it
    for (int i = 0; i < 4; i++) send_ks(8'($urandom));
    k0 = 8'($urandom); x0 = 8'($urandom);
    bus.ks_valid = 1; bus.ks_byte = k0;
    repeat (3) step();
    chk("t3_full", bus.ks_ready, 0);
    base = out_log.size();
    start_msg(1);
    ks_wait();
    send_din(x0);
    wait_done(20);
    chk("t3_fresh", log_get(base), x0 ^ k0);

    // Output backpressure
    k0 = 8'($urandom); k1 = 8'($urandom); x0 = 8'($urandom); x1 = 8'($urandom);
    bus.dout_ready = 0;
    base = out_log.size();
    start_msg(2);
    send_ks(k0); send_ks(k1);
    send_din(x0);
    bus.din_valid = 1; bus.din = x1;
    repeat (5) step();
    chk("t4_din_ready", bus.din_ready, 0);
    chk("t4_dout_hold", bus.dout, x0 ^ k0);
    bus.dout_ready = 1;
    din_wait();
    wait_done(20);
    chk("t4_b0", log_get(base), x0 ^ k0);
    chk("t4_b1", log_get(base + 1), x1 ^ k1);

    // Data waiting on an empty keystream FIFO
    k0 = 8'($urandom); x0 = 8'($urandom);
    base = out_log.size();
    start_msg(1);
    bus.din_valid = 1; bus.din = x0;
    repeat (4) step();
    chk("t5_stall", bus.din_ready, 0);
    send_ks(k0);
    din_wait();
    wait_done(20);
    chk("t5_b0", log_get(base), x0 ^ k0);

    // Reset in the middle of a message with a byte in flight
    bus.dout_ready = 0;
    start_msg(4);
    for (int i = 0; i < 4; i++) send_ks(8'($urandom));
    send_din(8'($urandom));
    rst = 1;
    #1;
    chk("t6_dout_valid", bus.dout_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_byte_count", byte_count, 0);
    repeat (2) step();
    rst = 0;
    bus.dout_ready = 1;
    k0 = 8'($urandom); x0 = 8'($urandom);
    base = out_log.size();
    start_msg(1);
    send_ks(k0); send_din(x0);
    wait_done(20);
    chk("t6_b0", log_get(base), x0 ^ k0);
    chk("t6_count", byte_count, 1);

    // Randomized messages with random gaps and backpressure, plus ignored starts
    ks_auto = 1; din_auto = 1; rdy_auto = 1;
    for (int i = 0; i < 25; i++) begin
      int len = $urandom_range(0, 12);
      start_msg(len);
      if (len >= 8) begin
        step(); step();
        start = 1; msg_len = LEN_W'($urandom_range(1, 5));
        step();
        start = 0;
      end
      wait_done(400);
    end
    ks_auto = 0; din_auto = 0; rdy_auto = 0;
    bus.ks_valid = 0; bus.din_valid = 0;
    repeat (3) step();
    chk("final_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
